// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice.
// Contents:
//   - alu_op_t      : 3-bit ALU opcode
//   - Flag*         : positions of N/Z/C/V inside the ALU's 32-bit flags word
//   - sched_state_t : scheduler FSM states
//   - op_latency()  : cycles the ALU operands are held for a given op
package alu_pkg;

  typedef enum logic [2:0] {
    AluAdd     = 3'b000,
    AluSub     = 3'b001,
    AluAnd     = 3'b010,
    AluOr      = 3'b011,
    AluMul     = 3'b100,
    AluDiv     = 3'b101,
    AluNot     = 3'b110,
    AluIllegal = 3'b111
  } alu_op_t;

  localparam int unsigned FlagN = 31;
  localparam int unsigned FlagZ = 30;
  localparam int unsigned FlagC = 29;
  localparam int unsigned FlagV = 28;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } sched_state_t;

  // Width of the hold counter; covers any practical MUL/DIV cycle count.
  localparam int unsigned CntW = 16;

  // Number of EXEC edges for an op. A zero cycle count is treated as 1 so
  // the counter can never underflow.
  function automatic logic [CntW-1:0] op_latency(alu_op_t op, int unsigned mul_cyc,
                                                 int unsigned div_cyc);
    logic [CntW-1:0] lat;
    case (op)
      AluMul:  lat = (mul_cyc == 0) ? CntW'(1) : CntW'(mul_cyc);
      AluDiv:  lat = (div_cyc == 0) ? CntW'(1) : CntW'(div_cyc);
      default: lat = CntW'(1);
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Bundle of the two request channels, the response channel and busy for
// alu_sched.
//   master : requester/consumer side (drives reqN_valid/a/b/op, rsp_ready)
//   slave  : scheduler side (drives reqN_ready, rsp_*, busy)
interface alu_sched_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_op;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  logic        busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
  );

endinterface

// File: rtl/alu_sched_alu.sv
// Shared 32-bit ALU datapath (purely combinational).
// Ports:
//   a_i, b_i  : operands
//   op_i      : opcode (alu_op_t)
//   alu_out_o : result
//   flags_o   : {N,Z,C,V} in bits 31:28, remaining bits zero
// Flag rules: add C = carry out; sub C = borrow (a < b unsigned); add/sub V =
// signed overflow; mul is unsigned with V = upper product word non-zero;
// div is unsigned, divide-by-zero returns 0 with C set.
module alu_sched_alu
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     op_i,
  output logic [31:0] alu_out_o,
  output logic [31:0] flags_o
);

  logic [32:0] sum;
  logic [63:0] prod;
  logic [31:0] res;
  logic        c;
  logic        v;

  always_comb begin
    sum  = '0;
    prod = '0;
    res  = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op_i)
      AluAdd: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        res = sum[31:0];
        c   = sum[32];
        v   = (a_i[31] == b_i[31]) && (res[31] != a_i[31]);
      end
      AluSub: begin
        sum = {1'b0, a_i} - {1'b0, b_i};
        res = sum[31:0];
        c   = sum[32];
        v   = (a_i[31] != b_i[31]) && (res[31] != a_i[31]);
      end
      AluAnd: res = a_i & b_i;
      AluOr:  res = a_i | b_i;
      AluNot: res = ~a_i;
      AluMul: begin
        prod = {32'd0, a_i} * {32'd0, b_i};
        res  = prod[31:0];
        v    = |prod[63:32];
      end
      AluDiv: begin
        if (b_i == 32'd0) begin
          res = '0;
          c   = 1'b1;
        end else begin
          res = a_i / b_i;
        end
      end
      default: res = '0;
    endcase
  end

  assign alu_out_o = res;
  assign flags_o   = {res[31], (res == 32'd0), c, v, 28'd0};

endmodule

// File: rtl/alu_sched.sv
// alu_sched: two-port arbitration and sequencing front-end for the shared ALU.
// Accepts one op at a time, holds its operands on the ALU for op_latency()
// edges, then presents the registered result/flags on the response channel.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_sched_if.slave (req0/req1 valid/ready + operands, response
//           valid/ready + id/result/flags/err, busy)
// Parameters:
//   MUL_CYC : hold cycles for mul (min 1)
//   DIV_CYC : hold cycles for div (min 1)
// Build option:
//   ALU_SCHED_RR_EN : round-robin arbitration when both ports are valid;
//                     undefined gives fixed priority with port 0 winning.
module alu_sched
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYC = 2,
  parameter int unsigned DIV_CYC = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_sched_if.slave bus
);

  sched_state_t    state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  alu_op_t         op_q, op_d;
  logic            id_q, id_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_result_q, rsp_result_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

`ifdef ALU_SCHED_RR_EN
  logic            last_q, last_d;
`endif

  logic            gnt_valid;
  logic            gnt_id;
  logic [31:0]     gnt_a;
  logic [31:0]     gnt_b;
  alu_op_t         gnt_op;

  logic [31:0]     alu_out;
  logic [31:0]     alu_flags;
  logic            unused_flags;

  // Arbiter: picks at most one requester among those currently valid.
  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
`ifdef ALU_SCHED_RR_EN
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = bus.req1_valid;
    end
`else
    gnt_id = ~bus.req0_valid;
`endif
    gnt_a  = gnt_id ? bus.req1_a : bus.req0_a;
    gnt_b  = gnt_id ? bus.req1_b : bus.req0_b;
    gnt_op = gnt_id ? alu_op_t'(bus.req1_op) : alu_op_t'(bus.req0_op);
  end

  // rst_n gates ready so nothing looks accepted while reset is held.
  assign bus.req0_ready = rst_n && (state_q == StIdle) && gnt_valid && !gnt_id;
  assign bus.req1_ready = rst_n && (state_q == StIdle) && gnt_valid && gnt_id;

  // ALU sees only the captured operands, so request ports may change freely
  // once the handshake is done.
  alu_sched_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .alu_out_o(alu_out),
    .flags_o  (alu_flags)
  );

  assign unused_flags = ^alu_flags[FlagV-1:0];

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
`ifdef ALU_SCHED_RR_EN
    last_d       = last_q;
`endif

    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          a_d     = gnt_a;
          b_d     = gnt_b;
          op_d    = gnt_op;
          id_d    = gnt_id;
          cnt_d   = op_latency(gnt_op, MUL_CYC, DIV_CYC) - CntW'(1);
          state_d = StExec;
`ifdef ALU_SCHED_RR_EN
          last_d  = gnt_id;
`endif
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          if (op_q == AluIllegal) begin
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_err_d    = 1'b1;
          end else begin
            rsp_result_d = alu_out;
            rsp_flags_d  = alu_flags[FlagN:FlagV];
            rsp_err_d    = 1'b0;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= AluAdd;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_SCHED_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
`ifdef ALU_SCHED_RR_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed vector table, hand-written
// backpressure / arbitration / mid-op reset sequences, then random ops checked
// against an arithmetic reference model.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int unsigned MulCyc = 2;
  localparam int unsigned DivCyc = 4;
  localparam int NumVec = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sched_if bus();

  alu_sched #(
    .MUL_CYC(MulCyc),
    .DIV_CYC(DivCyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic [3:0]  fl;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[NumVec];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {err, flags[3:0], result[31:0]} from plain integer arithmetic.
  function automatic logic [36:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned ua, ub, wide;
    int ia, ib;
    longint sa, sb, s, imax, imin;
    logic [31:0] res;
    logic c, v;
    ua = a; ub = b; ia = a; ib = b; sa = ia; sb = ib;
    imax = 2147483647;
    imin = -imax - 1;
    res = '0; c = 1'b0; v = 1'b0; wide = 0; s = 0;
    case (op)
      3'b000: begin
        wide = ua + ub; res = wide[31:0]; c = (wide >> 32) != 0;
        s = sa + sb; v = (s > imax) || (s < imin);
      end
      3'b001: begin
        res = a - b; c = ua < ub;
        s = sa - sb; v = (s > imax) || (s < imin);
      end
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b110: res = ~a;
      3'b100: begin
        wide = ua * ub; res = wide[31:0]; v = (wide >> 32) != 0;
      end
      3'b101: begin
        if (b == 0) begin res = '0; c = 1'b1; end
        else res = a / b;
      end
      default: return {1'b1, 4'b0000, 32'd0};
    endcase
    return {1'b0, res[31], (res == 32'd0), c, v, res};
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (op == 3'b100) return MulCyc;
    if (op == 3'b101) return DivCyc;
    return 1;
  endfunction

  task automatic drive(input int port, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  // One full transaction on a single port; returns captured response and the
  // number of edges from accept until rsp_valid was seen.
  task automatic do_op(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input int delay,
                       output logic [31:0] res, output logic [3:0] fl, output logic er,
                       output logic id, output int lat);
    int n;
    logic rdy;
    res = '0; fl = '0; er = 1'b0; id = 1'b0; lat = 0;
    @(negedge clk);
    drive(port, 1'b1, a, b, op);
    #1;
    n = 0;
    rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1;
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      n++;
    end
    if (!rdy) begin
      drive(port, 1'b0, a, b, op);
      check("accept_timeout", 0, 1);
      return;
    end
    @(posedge clk); #1;
    // Scramble the port so a design reading the port after accept misbehaves.
    drive(port, 1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)));
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 1) check("busy_exec", bus.busy, 1);
    end while (!bus.rsp_valid && lat < 30);
    if (!bus.rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    res = bus.rsp_result; fl = bus.rsp_flags; er = bus.rsp_err; id = bus.rsp_id;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("hold_stable", {bus.rsp_valid, bus.rsp_result, bus.rsp_flags},
            {1'b1, res, fl});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_fall", bus.rsp_valid, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, b;
    logic [3:0]  f;
    logic        e, id, seen;
    logic [2:0]  op;
    logic [3:0]  arb_exp;
    logic [36:0] m;
    int          lat, nresp, port;

    vecs[0]  = '{0, 32'd3,          32'd1,          3'b000, 32'd4,          4'b0000, 1'b0, 1};
    vecs[1]  = '{1, 32'h4000_0000,  32'h4000_0000,  3'b000, 32'h8000_0000,  4'b1001, 1'b0, 1};
    vecs[2]  = '{0, 32'h8000_0000,  32'h8000_0000,  3'b100, 32'd0,          4'b0101, 1'b0,
                 MulCyc};
    vecs[3]  = '{1, 32'd4,          32'd0,          3'b101, 32'd0,          4'b0110, 1'b0,
                 DivCyc};
    vecs[4]  = '{0, 32'd9,          32'd3,          3'b111, 32'd0,          4'b0000, 1'b1, 1};
    vecs[5]  = '{1, 32'd5,          32'd9,          3'b001, 32'hFFFF_FFFC,  4'b1010, 1'b0, 1};
    vecs[6]  = '{0, 32'd0,          32'd0,          3'b110, 32'hFFFF_FFFF,  4'b1000, 1'b0, 1};
    vecs[7]  = '{1, 32'h0000_F0F0,  32'h0000_0F0F,  3'b010, 32'd0,          4'b0100, 1'b0, 1};
    vecs[8]  = '{0, 32'd1,          32'd2,          3'b011, 32'd3,          4'b0000, 1'b0, 1};
    vecs[9]  = '{0, 32'd100,        32'd7,          3'b101, 32'd14,         4'b0000, 1'b0,
                 DivCyc};
    vecs[10] = '{1, 32'h8000_0000,  32'd1,          3'b001, 32'h7FFF_FFFF,  4'b0001, 1'b0, 1};

`ifdef ALU_SCHED_RR_EN
    arb_exp = 4'b1010;
`else
    arb_exp = 4'b0000;
`endif

    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_flags", bus.rsp_flags, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < NumVec; i++) begin
      do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, 0, r, f, e, id, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_flags", i), f, vecs[i].fl);
      check($sformatf("vec%0d_err", i), e, vecs[i].err);
      check($sformatf("vec%0d_id", i), id, (vecs[i].port != 0));
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Backpressure: response held 5 cycles with both requesters waiting
    @(negedge clk);
    drive(0, 1'b1, 32'd6, 32'd7, 3'b100);
    #1 check("bp_accept_ready", bus.req0_ready, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!bus.rsp_valid && lat < 30);
    check("bp_latency", lat, MulCyc);
    check("bp_result", bus.rsp_result, 42);
    drive(0, 1'b1, 32'd1, 32'd1, 3'b000);
    drive(1, 1'b1, 32'd2, 32'd2, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_id, bus.rsp_err},
            {1'b1, 32'd42, 4'b0000, 1'b0, 1'b0});
      check("bp_ready_low", {bus.req0_ready, bus.req1_ready}, 0);
    end
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_valid_fall", bus.rsp_valid, 0);
    drive(0, 1'b1, 32'd1, 32'd1, 3'b000);
    #1 check("bp_ready_back", bus.req0_ready, 1);
    drive(0, 1'b0, '0, '0, '0);

    // Arbitration: both ports continuously valid with sub 7-7, from reset
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 32'd7, 32'd7, 3'b001);
    drive(1, 1'b1, 32'd7, 32'd7, 3'b001);
    bus.rsp_ready = 1'b1;
    nresp = 0;
    for (int cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
      @(negedge clk);
      check("arb_one_ready", bus.req0_ready & bus.req1_ready, 0);
      if (bus.rsp_valid) begin
        check($sformatf("arb%0d_id", nresp), bus.rsp_id, arb_exp[nresp]);
        check($sformatf("arb%0d_result", nresp), bus.rsp_result, 0);
        check($sformatf("arb%0d_flags", nresp), bus.rsp_flags, 4'b0100);
        nresp++;
        if (nresp == 4) begin
          drive(0, 1'b0, '0, '0, '0);
          drive(1, 1'b0, '0, '0, '0);
        end
      end
    end
    check("arb_count", nresp, 4);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Reset in the middle of a div
    do_op(1, 32'h55, 32'h0, 3'b011, 0, r, f, e, id, lat);
    check("pre_rst_result", r, 32'h55);
    check("pre_rst_id", id, 1);
    @(negedge clk);
    drive(1, 1'b1, 32'd100, 32'd5, 3'b101);
    #1 check("div_ready", bus.req1_ready, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    check("div_busy", {bus.busy, bus.rsp_valid}, 2'b10);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_outputs",
          {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err, bus.busy},
          0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid | bus.busy;
    end
    check("mid_rst_no_rsp", seen, 0);

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      port = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (op == 3'b101) b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      if (op == 3'b100 && $urandom_range(0, 1) == 0) begin
        a = 32'($urandom_range(0, 65535));
        b = 32'($urandom_range(0, 65535));
      end
      m = model(op, a, b);
      do_op(port, a, b, op, $urandom_range(0, 3), r, f, e, id, lat);
      check($sformatf("rnd%0d_result", i), r, m[31:0]);
      check($sformatf("rnd%0d_flags", i), f, m[35:32]);
      check($sformatf("rnd%0d_err", i), e, m[36]);
      check($sformatf("rnd%0d_id", i), id, (port != 0));
      check($sformatf("rnd%0d_latency", i), lat, exp_lat(op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
